// File: rtl/mem_io_responder.sv
// Purpose : byte-wide CPU memory responder: 128 KB RAM, UART RX/TX byte FIFOs, cycle-counter snapshot, stop/overflow flags.
// Latency : every read returns on mem_din_o one cycle after its address; writes take effect at the closing clk_in edge.
// Backpress: rdy_o (registered) is low while the TX FIFO holds >= FIFO_DEPTH-2 bytes; RX is throttled by rx_ready_o.
//
// Ports of mem_io_responder:
//   clk_in, rst_in                      clock, synchronous active-high reset
//   mem_a_i, mem_wr_i, mem_dout_i       CPU address / write strobe / write data (one access per cycle)
//   mem_din_o                           CPU read data, valid the cycle after the read address
//   rx_valid_i, rx_data_i, rx_ready_o   UART receive byte stream into the RX FIFO
//   tx_valid_o, tx_data_o, tx_ready_i   UART transmit byte stream out of the TX FIFO
//   rdy_o                               CPU ready (low = pause)
//   program_stop_o, tx_overflow_o       sticky flags, cleared only by reset

// Purpose : generic synchronous byte FIFO with occupancy count and next-cycle count.
// Latency : head byte visible combinationally; a push is visible at the head one cycle later.
// Backpress: a push to a full FIFO is accepted only when a pop happens in the same cycle, otherwise dropped.
module mem_io_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_dat_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_nxt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_ok = push_i & (~full | pop_i);
    assign pop_ok  = pop_i & ~empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;
endmodule

module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a_i,
    input  logic        mem_wr_i,
    input  logic [7:0]  mem_dout_i,
    output logic [7:0]  mem_din_o,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        rdy_o,
    output logic        program_stop_o,
    output logic        tx_overflow_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] RDY_LIM  = CNT_W'(FIFO_DEPTH - 2);

    // Only address bits 17:0 are decoded; the rest are ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_a_i[31:18];

    // ---------------- address decode ----------------
    logic        rd_acc;
    logic        wr_acc;
    logic        sel_ram;
    logic        sel_io;
    logic [15:0] io_off;
    logic        io_data;   // offset 0: RX pop / TX push
    logic        io_stop;   // offset 4: counter snapshot (read) / stop (write)
    logic        io_cnt;    // offsets 4..7: snapshot bytes

    assign rd_acc  = ~mem_wr_i;
    assign wr_acc  = mem_wr_i;
    assign sel_ram = ~mem_a_i[17];
    assign sel_io  = (mem_a_i[17:16] == 2'b11);
    assign io_off  = mem_a_i[15:0];
    assign io_data = sel_io & (io_off == 16'h0000);
    assign io_stop = sel_io & (io_off == 16'h0004);
    assign io_cnt  = sel_io & (io_off[15:2] == 14'h0001);

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_head;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] rx_count_nxt_unused;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_nonempty;

    assign rx_ready_o  = (rx_count != FULL_CNT);
    assign rx_push     = rx_valid_i & rx_ready_o;
    assign rx_pop      = rd_acc & io_data;
    assign rx_nonempty = (rx_count != '0);

    mem_io_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .CNT_W(CNT_W)) u_rx_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push_i      (rx_push),
        .push_dat_i  (rx_data_i),
        .pop_i       (rx_pop),
        .head_dat_o  (rx_head),
        .count_o     (rx_count),
        .count_nxt_o (rx_count_nxt_unused)
    );

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_head;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] tx_count_nxt;
    logic             tx_push;
    logic [7:0]       tx_push_dat;
    logic             tx_pop;
    logic             tx_full;

    // A zero byte written to the data port is swallowed; the stop port always emits 0x00.
    assign tx_push     = wr_acc & ((io_data & (mem_dout_i != 8'h00)) | io_stop);
    assign tx_push_dat = io_stop ? 8'h00 : mem_dout_i;
    assign tx_valid_o  = (tx_count != '0);
    assign tx_pop      = tx_valid_o & tx_ready_i;
    assign tx_full     = (tx_count == FULL_CNT);
    assign tx_data_o   = tx_head;

    mem_io_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .CNT_W(CNT_W)) u_tx_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push_i      (tx_push),
        .push_dat_i  (tx_push_dat),
        .pop_i       (tx_pop),
        .head_dat_o  (tx_head),
        .count_o     (tx_count),
        .count_nxt_o (tx_count_nxt)
    );

    // ---------------- RAM ----------------
    logic [7:0]            ram_q [2**RAM_ADDR_W];
    logic [7:0]            ram_rd_q;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  ram_we;

    assign ram_addr = mem_a_i[RAM_ADDR_W-1:0];
    assign ram_we   = wr_acc & sel_ram & ~rst_in;

    // Contents survive reset; the read register is masked by ram_sel_q instead.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram_q[ram_addr] <= mem_dout_i;
        ram_rd_q <= ram_q[ram_addr];
    end

    // ---------------- I/O read data, counter, flags ----------------
    logic [31:0] cyc_cnt_q;
    logic [31:0] snap_q;
    logic [7:0]  io_rd_d;
    logic [7:0]  io_rd_q;
    logic        ram_sel_q;
    logic        rdy_q;
    logic        stop_q;
    logic        ovf_q;

    always_comb begin
        io_rd_d = 8'h00;
        if (rd_acc & io_data & rx_nonempty) begin
            io_rd_d = rx_head;
        end else if (rd_acc & io_cnt) begin
            // Byte 0 comes straight from the live counter, the value being latched this cycle.
            case (io_off[1:0])
                2'd0:    io_rd_d = cyc_cnt_q[7:0];
                2'd1:    io_rd_d = snap_q[15:8];
                2'd2:    io_rd_d = snap_q[23:16];
                default: io_rd_d = snap_q[31:24];
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cyc_cnt_q <= 32'h0;
            snap_q    <= 32'h0;
            io_rd_q   <= 8'h00;
            ram_sel_q <= 1'b0;
            rdy_q     <= 1'b1;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (rd_acc & io_stop) snap_q <= cyc_cnt_q;
            io_rd_q   <= io_rd_d;
            ram_sel_q <= rd_acc & sel_ram;
            // Based on the next count so rdy_o tracks the occupancy the FIFO is about to have.
            rdy_q     <= (tx_count_nxt < RDY_LIM);
            if (wr_acc & io_stop) stop_q <= 1'b1;
            if (tx_push & tx_full & ~tx_pop) ovf_q <= 1'b1;
        end
    end

    // Both mux inputs and the select are registers, so mem_din_o is a clean registered value.
    assign mem_din_o      = ram_sel_q ? ram_rd_q : io_rd_q;
    assign rdy_o          = rdy_q;
    assign program_stop_o = stop_q;
    assign tx_overflow_o  = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Purpose : self-checking bench for mem_io_responder using a directed vector table plus hand-written sequences.
// Latency : each vector is one CPU cycle; outputs are compared 1 time unit after the edge that consumes it.
// Backpress: tx_ready_i / rx_valid_i are driven per vector to exercise FIFO full, drain and overflow cases.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a_i;
    logic        mem_wr_i;
    logic [7:0]  mem_dout_i;
    logic [7:0]  mem_din_o;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        rdy_o;
    logic        program_stop_o;
    logic        tx_overflow_o;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(.RAM_ADDR_W(17), .FIFO_DEPTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a_i        (mem_a_i),
        .mem_wr_i       (mem_wr_i),
        .mem_dout_i     (mem_dout_i),
        .mem_din_o      (mem_din_o),
        .rx_valid_i     (rx_valid_i),
        .rx_data_i      (rx_data_i),
        .rx_ready_o     (rx_ready_o),
        .tx_valid_o     (tx_valid_o),
        .tx_data_o      (tx_data_o),
        .tx_ready_i     (tx_ready_i),
        .rdy_o          (rdy_o),
        .program_stop_o (program_stop_o),
        .tx_overflow_o  (tx_overflow_o)
    );

    // One CPU cycle of stimulus and the outputs expected right after its edge.
    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic [7:0]  e_din;
        logic        e_rdy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_rxr;
        logic        e_stop;
        logic        e_ovf;
    } vec_t;

    vec_t  tbl[$];
    string names[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic vec_t mkv(input logic wr, input logic [31:0] a, input logic [7:0] d,
                                 input logic rxv, input logic [7:0] rxd, input logic txr,
                                 input logic [7:0] e_din, input logic e_rdy, input logic e_txv,
                                 input logic [7:0] e_txd, input logic e_rxr, input logic e_stop,
                                 input logic e_ovf);
        vec_t v;
        v.wr = wr;  v.a = a;  v.d = d;  v.rxv = rxv;  v.rxd = rxd;  v.txr = txr;
        v.e_din = e_din;  v.e_rdy = e_rdy;  v.e_txv = e_txv;  v.e_txd = e_txd;
        v.e_rxr = e_rxr;  v.e_stop = e_stop;  v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic add(input string nm, input vec_t v);
        tbl.push_back(v);
        names.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", nm, act, exp);
        end
    endtask

    task automatic idle();
        mem_wr_i   = 1'b0;
        mem_a_i    = 32'h0002_0000;
        mem_dout_i = 8'h00;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_flags(input string nm, input logic e_rdy, input logic e_txv,
                               input logic e_rxr, input logic e_stop, input logic e_ovf);
        check({nm, ".rdy"},  rdy_o,          e_rdy);
        check({nm, ".txv"},  tx_valid_o,     e_txv);
        check({nm, ".rxr"},  rx_ready_o,     e_rxr);
        check({nm, ".stop"}, program_stop_o, e_stop);
        check({nm, ".ovf"},  tx_overflow_o,  e_ovf);
    endtask

    task automatic apply(input vec_t v, input string nm);
        mem_wr_i   = v.wr;
        mem_a_i    = v.a;
        mem_dout_i = v.d;
        rx_valid_i = v.rxv;
        rx_data_i  = v.rxd;
        tx_ready_i = v.txr;
        step();
        check({nm, ".din"}, mem_din_o, v.e_din);
        check_flags(nm, v.e_rdy, v.e_txv, v.e_rxr, v.e_stop, v.e_ovf);
        if (v.e_txv) check({nm, ".txd"}, tx_data_o, v.e_txd);
    endtask

    task automatic pulse_reset(input logic [31:0] a);
        idle();
        mem_a_i = a;
        rst_in  = 1'b1;
        step();
        rst_in  = 1'b0;
        idle();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] e;

        idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("reset.din", mem_din_o, 8'h00);
        check_flags("reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // RAM, unmapped space, upper-address aliasing, other I/O offsets.
        add("ram_wr",     mkv(1, 32'h0000_0010, 8'hA5, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("ram_rd",     mkv(0, 32'h0000_0010, 8'h00, 0, 8'h00, 0, 8'hA5, 1, 0, 8'h00, 1, 0, 0));
        add("ram_wr_top", mkv(1, 32'h0001_FFFF, 8'h3C, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("ram_rd_top", mkv(0, 32'h0001_FFFF, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 0, 8'h00, 1, 0, 0));
        add("unm_wr",     mkv(1, 32'h0002_0010, 8'h77, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("unm_rd",     mkv(0, 32'h0002_0010, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("ram_alias",  mkv(0, 32'h0000_0010, 8'h00, 0, 8'h00, 0, 8'hA5, 1, 0, 8'h00, 1, 0, 0));
        add("hi_bits",    mkv(0, 32'hFFFC_0010, 8'h00, 0, 8'h00, 0, 8'hA5, 1, 0, 8'h00, 1, 0, 0));
        add("io_oth_wr",  mkv(1, 32'h0003_0008, 8'h55, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("io_oth_rd",  mkv(0, 32'h0003_0008, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        // RX stream: two pushes, three pops, then push+pop on an empty FIFO.
        add("rx_push1",   mkv(0, 32'h0002_0000, 8'h00, 1, 8'h41, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("rx_push2",   mkv(0, 32'h0002_0000, 8'h00, 1, 8'h42, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("rx_pop1",    mkv(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0, 8'h41, 1, 0, 8'h00, 1, 0, 0));
        add("rx_pop2",    mkv(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0, 8'h42, 1, 0, 8'h00, 1, 0, 0));
        add("rx_pop3",    mkv(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("rx_pushpop", mkv(0, 32'h0003_0000, 8'h00, 1, 8'h99, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        add("rx_pop4",    mkv(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0, 8'h99, 1, 0, 8'h00, 1, 0, 0));
        // TX ordering, and a 0x00 write that must not be queued.
        add("tx_p10",     mkv(1, 32'h0003_0000, 8'h10, 0, 8'h00, 0, 8'h00, 1, 1, 8'h10, 1, 0, 0));
        add("tx_p20",     mkv(1, 32'h0003_0000, 8'h20, 0, 8'h00, 0, 8'h00, 1, 1, 8'h10, 1, 0, 0));
        add("tx_p30",     mkv(1, 32'h0003_0000, 8'h30, 0, 8'h00, 0, 8'h00, 1, 1, 8'h10, 1, 0, 0));
        add("tx_zero",    mkv(1, 32'h0003_0000, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 8'h10, 1, 0, 0));
        add("tx_d1",      mkv(0, 32'h0002_0000, 8'h00, 0, 8'h00, 1, 8'h00, 1, 1, 8'h20, 1, 0, 0));
        add("tx_d2",      mkv(0, 32'h0002_0000, 8'h00, 0, 8'h00, 1, 8'h00, 1, 1, 8'h30, 1, 0, 0));
        add("tx_d3",      mkv(0, 32'h0002_0000, 8'h00, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 1, 0, 0));
        // Nine pushes with the sink stalled: rdy_o low from count 6, ninth push dropped.
        for (int k = 1; k <= 9; k++)
            add($sformatf("ovf_push%0d", k),
                mkv(1, 32'h0003_0000, 8'h31, 0, 8'h00, 0, 8'h00, (k < 6), 1, 8'h31, 1, 0, (k == 9)));
        for (int j = 1; j <= 8; j++)
            add($sformatf("ovf_drain%0d", j),
                mkv(0, 32'h0002_0000, 8'h00, 0, 8'h00, 1, 8'h00, ((8 - j) < 6), (j < 8), 8'h31, 1, 0, 1));
        // Stop port: sets the flag and emits 0x00.
        add("stop_wr",    mkv(1, 32'h0003_0004, 8'h5A, 0, 8'h00, 0, 8'h00, 1, 1, 8'h00, 1, 1, 1));
        add("stop_drain", mkv(0, 32'h0002_0000, 8'h00, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 1, 1, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], names[i]);

        // Reset with TX half full, stop set, an RX byte queued and a RAM read in flight.
        for (int i = 0; i < 4; i++) begin
            b = 8'hD1 + 8'(i);
            apply(mkv(1, 32'h0003_0000, b, (i == 0), 8'h66, 0, 8'h00, 1, 1, 8'hD1, 1, 1, 1),
                  $sformatf("half_push%0d", i));
        end
        pulse_reset(32'h0000_0010);
        check("midrst.din", mem_din_o, 8'h00);
        check_flags("midrst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(mkv(0, 32'h0003_0004, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0), "rst_cnt0");
        apply(mkv(0, 32'h0003_0004, 8'h00, 0, 8'h00, 0, 8'h01, 1, 0, 8'h00, 1, 0, 0), "rst_cnt1");
        apply(mkv(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0), "rst_rx_empty");
        apply(mkv(0, 32'h0000_0010, 8'h00, 0, 8'h00, 0, 8'hA5, 1, 0, 8'h00, 1, 0, 0), "rst_ram");

        // TX full plus simultaneous push and pop: count stays 8, no overflow.
        for (int i = 0; i < 8; i++) begin
            b = 8'hC0 + 8'(i);
            apply(mkv(1, 32'h0003_0000, b, 0, 8'h00, 0, 8'h00, ((i + 1) < 6), 1, 8'hC0, 1, 0, 0),
                  $sformatf("full_push%0d", i));
        end
        apply(mkv(1, 32'h0003_0000, 8'h77, 0, 8'h00, 1, 8'h00, 0, 1, 8'hC1, 1, 0, 0), "full_pushpop");
        for (int j = 1; j <= 8; j++) begin
            e = (j < 7) ? (8'hC1 + 8'(j)) : 8'h77;
            apply(mkv(0, 32'h0002_0000, 8'h00, 0, 8'h00, 1, 8'h00, ((8 - j) < 6), (j < 8), e, 1, 0, 0),
                  $sformatf("full_drain%0d", j));
        end

        // RX full: rx_ready_o drops, a byte offered while full is refused.
        for (int i = 0; i < 8; i++) begin
            b = 8'hB0 + 8'(i);
            apply(mkv(0, 32'h0002_0000, 8'h00, 1, b, 0, 8'h00, 1, 0, 8'h00, (i < 7), 0, 0),
                  $sformatf("rxfull_push%0d", i));
        end
        apply(mkv(0, 32'h0003_0000, 8'h00, 1, 8'hEE, 0, 8'hB0, 1, 0, 8'h00, 1, 0, 0), "rxfull_pop0");
        for (int i = 1; i < 8; i++) begin
            b = 8'hB0 + 8'(i);
            apply(mkv(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0, b, 1, 0, 8'h00, 1, 0, 0),
                  $sformatf("rxfull_pop%0d", i));
        end
        apply(mkv(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0), "rxfull_empty");

        // Counter snapshot across a byte carry: counter reaches 0x1FF after 511 cycles.
        pulse_reset(32'h0002_0000);
        repeat (511) step();
        apply(mkv(0, 32'h0003_0004, 8'h00, 0, 8'h00, 0, 8'hFF, 1, 0, 8'h00, 1, 0, 0), "snap_b0");
        apply(mkv(0, 32'h0003_0005, 8'h00, 0, 8'h00, 0, 8'h01, 1, 0, 8'h00, 1, 0, 0), "snap_b1");
        apply(mkv(0, 32'h0003_0006, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0), "snap_b2");
        apply(mkv(0, 32'h0003_0007, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0), "snap_b3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter: RAM_ADDR_W, 17, byte-address width of on-chip RAM (128 KB).
REQ-002 Parameter: FIFO_DEPTH, 8, entries in each of the RX and TX byte FIFOs (power of two).
REQ-003 Port: clk_in  input  1  system clock; the only clock.
REQ-004 Port: rst_in  input  1  reset, synchronous, active-high.
REQ-005 Port: mem_a_i  input  32  CPU address bus; only bits 17:0 are decoded.
REQ-006 Port: mem_wr_i  input  1  1 = write, 0 = read, sampled every cycle.
REQ-007 Port: mem_dout_i  input  8  CPU write data.
REQ-008 Port: mem_din_o  output  8  read data returned to the CPU.
REQ-009 Port: rx_valid_i / rx_data_i / rx_ready_o  in/in/out  1/8/1  UART receive byte stream, valid/ready.
REQ-010 Port: tx_valid_o / tx_data_o / tx_ready_i  out/out/in  1/8/1  UART transmit byte stream, valid/ready.
REQ-011 Port: rdy_o  output  1  CPU ready; low requests a CPU pause.
REQ-012 Port: program_stop_o  output  1  sticky flag for program termination.
REQ-013 Port: tx_overflow_o  output  1  sticky flag for a dropped TX write.

Function
REQ-014 Decode: a[17:16]=11 selects I/O; a[17]=0 selects RAM at a[16:0]; a[17:16]=10 is unmapped.
REQ-015 RAM read: address presented in cycle N; the byte appears on mem_din_o in cycle N+1 from a registered output.
REQ-016 RAM write: the byte is stored at the clk_in edge ending cycle N; a read of the same address in cycle N+1 returns the new byte.
REQ-017 Unmapped access: a read returns 0x00 in N+1; a write has no effect.
REQ-018 Read of 0x30000: pops one RX FIFO byte, returned in N+1; an empty FIFO returns 0x00 and no pop occurs.
REQ-019 Repeated RX reads: a pop happens once per cycle the address is held with mem_wr_i=0; the CPU is responsible for single-cycle reads.
REQ-020 Cycle counter: 32-bit free-running counter; increments every cycle after reset; wraps from 0xFFFFFFFF to 0.
REQ-021 Counter snapshot: a read of 0x30004 latches the counter into a snapshot register and returns snapshot byte 0 (little-endian) in N+1.
REQ-022 Counter bytes: reads of 0x30005–0x30007 return snapshot bytes 1–3 without relatching.
REQ-023 Write to 0x30000: a non-zero byte pushes into the TX FIFO; a write of 0x00 is ignored.
REQ-024 Write to 0x30004: sets program_stop_o and pushes 0x00 into the TX FIFO.
REQ-025 Other I/O offsets: reads return 0x00; writes are ignored.
REQ-026 TX FIFO full: a push to a full FIFO drops the byte and sets tx_overflow_o.
REQ-027 TX push/pop same cycle: simultaneous push and pop is legal at any occupancy, including full; count is unchanged.
REQ-028 TX output: tx_valid_o=1 whenever the TX FIFO is non-empty; tx_data_o is the head byte; pop occurs on tx_valid_o & tx_ready_i.
REQ-029 RX input: rx_ready_o=1 iff the RX FIFO is not full; push occurs on rx_valid_i & rx_ready_o.
REQ-030 RX push/pop same cycle: both are legal in one cycle; a pop from empty returns 0x00 while the push is accepted.
REQ-031 Backpressure: rdy_o is registered; rdy_o=0 while TX count >= FIFO_DEPTH-2, otherwise 1.
REQ-032 Sticky flags: program_stop_o and tx_overflow_o clear only on reset.
REQ-033 FIFO pointers: wrap modulo FIFO_DEPTH; count is width log2(FIFO_DEPTH)+1.

Reset
REQ-034 When rst_in=1 at a clk_in edge: mem_din_o=0, counter=0, snapshot=0, both FIFOs empty, tx_valid_o=0, rx_ready_o=1 on the next cycle, rdy_o=1, program_stop_o=0, tx_overflow_o=0.
REQ-035 RAM contents are not reset.
REQ-036 Reset mid-operation aborts any pending read; mem_din_o=0 in the following cycle.

Verification
REQ-037 Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_din_o=0xA5 one cycle after the read address.
REQ-038 Push 0x41, 0x42 via RX; read 0x30000 three times -> 0x41, 0x42, 0x00; rx_ready_o stays 1.
REQ-039 Hold tx_ready_i=0; write 0x31 nine times to 0x30000 -> rdy_o falls after the 6th push, 8 bytes are queued, tx_overflow_o=1; releasing tx_ready_i drains 8 bytes of 0x31.
REQ-040 Write 0x00 to 0x30000 -> no TX push; write any value to 0x30004 -> program_stop_o=1 and 0x00 is emitted on TX.
REQ-041 Read 0x30004..0x30007 on consecutive cycles starting at counter=0x000001FF -> bytes FF, 01, 00, 00 (snapshot consistent across the carry).
REQ-042 Assert rst_in with the TX FIFO half full and program_stop_o=1 -> next cycle FIFOs are empty, flags are 0, counter=0, and RAM data is still readable unchanged.
